// File: rtl/winograd_output_transform_unit.sv
// winograd_output_transform_unit: Winograd F(4x4,3x3) output transform Y = A^T * M * A
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; tile_in is the 6x6 signed product tile M [row][col]
//   out_valid/out_ready output handshake; tile_out is the 4x4 signed result Y [row][col]
//   sat_flag            some element of the current tile_out was clamped
// Pass 1 (S_T) forms T = A^T*M, pass 2 (S_Y) forms Y = T*A, rounds, shifts, saturates.
module winograd_output_transform_unit #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  tile_in [0:5][0:5],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] tile_out [0:3][0:3],
  output logic                    sat_flag
);
  localparam int ACC_W = IN_W + 10;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  // half-LSB rounding constant; the inner guard keeps the shift amount legal when OUT_SHIFT=0
  localparam logic signed [ACC_W-1:0] RND =
    OUT_SHIFT > 0 ? ACC_W'(1) <<< (OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0) : '0;
  typedef enum logic [1:0] {S_IDLE, S_T, S_Y, S_OUT} state_t;
  state_t                   state_q;
  logic                     in_ready_q, out_valid_q, sat_q, sat_d;
  logic signed [ACC_W-1:0]  m_q [0:5][0:5];
  logic signed [ACC_W-1:0]  t_q [0:3][0:5];
  logic signed [ACC_W-1:0]  t_d [0:3][0:5];
  logic signed [OUT_W-1:0]  y_q [0:3][0:3];
  logic signed [OUT_W-1:0]  y_d [0:3][0:3];
  logic signed [ACC_W-1:0]  y_c, r_c;
  // one row of A^T applied to a 6-vector, shared by both passes
  function automatic logic signed [ACC_W-1:0] at_row(input logic [1:0] i,
      input logic signed [ACC_W-1:0] v0, v1, v2, v3, v4, v5);
    logic signed [ACC_W-1:0] s12, d12, s34, d34;
    s12 = v1 + v2;
    d12 = v1 - v2;
    s34 = v3 + v4;
    d34 = v3 - v4;
    return i == 2'd0 ? v0 + s12 + s34 :
           i == 2'd1 ? d12 + (d34 <<< 1) :
           i == 2'd2 ? s12 + (s34 <<< 2) : d12 + (d34 <<< 3) + v5;
  endfunction
  always_comb begin
    t_d = '{default: '0};
    y_d = '{default: '0};
    sat_d = 1'b0;
    y_c = '0;
    r_c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 6; j++)
        t_d[i][j] = at_row(2'(i), m_q[0][j], m_q[1][j], m_q[2][j], m_q[3][j], m_q[4][j], m_q[5][j]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        y_c = at_row(2'(j), t_q[i][0], t_q[i][1], t_q[i][2], t_q[i][3], t_q[i][4], t_q[i][5]);
        r_c = (y_c + RND) >>> OUT_SHIFT;
        y_d[i][j] = r_c > MAXV ? MAXV[OUT_W-1:0] : r_c < MINV ? MINV[OUT_W-1:0] : r_c[OUT_W-1:0];
        sat_d = sat_d | (r_c > MAXV) | (r_c < MINV);
      end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      m_q         <= '{default: '0};
      t_q         <= '{default: '0};
      y_q         <= '{default: '0};
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
              m_q[r][c] <= ACC_W'(tile_in[r][c]);
          in_ready_q <= 1'b0;
          state_q    <= S_T;
        end
        S_T: begin
          t_q     <= t_d;
          state_q <= S_Y;
        end
        S_Y: begin
          y_q         <= y_d;
          sat_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;
  assign tile_out  = y_q;
endmodule
